// File: rtl/mem_burst_ctrl.sv
// Burst engine: WRITE / READ / CLEAR bursts from one command into NUM_BANKS 1-cycle SRAMs.
// Latency: writes issue in the beat's own cycle; first read beat 2 cycles after the accept edge, then 1/cycle.
// Backpressure: wr_ready only in WRITE; rd_ready low parks data in a 2-entry buffer and pauses read issue.
//
// Ports:
//   clk, reset                     rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready/op/bank/addr/len  command channel (op 00 NOP, 01 WRITE, 10 READ, 11 CLEAR)
//   wr_valid/ready/data            write-data stream
//   rd_valid/ready/data            read-data stream (registered buffer head)
//   mem_we/addr/data_in            SRAM drive, one-hot write enable, shared address and data
//   mem_data_out                   SRAM read data, bank b at [b*DATA_W +: DATA_W]
//   busy, err                      activity flag, 1-cycle pulse for a rejected bank
module mem_burst_ctrl #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int NUM_BANKS = 2,
   parameter int LEN_W     = 8,
   localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [1:0]                  cmd_op,
   input  logic [BANK_W-1:0]           cmd_bank,
   input  logic [ADDR_W-1:0]           cmd_addr,
   input  logic [LEN_W-1:0]            cmd_len,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [DATA_W-1:0]           wr_data,
   output logic                        rd_valid,
   input  logic                        rd_ready,
   output logic [DATA_W-1:0]           rd_data,
   output logic [NUM_BANKS-1:0]        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_data_in,
   input  logic [NUM_BANKS*DATA_W-1:0] mem_data_out,
   output logic                        busy,
   output logic                        err
);

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;

   localparam logic [BANK_W:0] BANK_LIMIT = (BANK_W+1)'(NUM_BANKS);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CLEAR, S_DRAIN} state_t;

   state_t              state;
   logic [BANK_W-1:0]   bank;
   logic [ADDR_W-1:0]   addr;
   logic [LEN_W-1:0]    cnt;
   logic                err_q;
   logic                inflight;      // a read was issued last cycle; its data is on mem_data_out now
   logic [1:0]          fifo_cnt;
   logic [DATA_W-1:0]   fifo_q0;       // head
   logic [DATA_W-1:0]   fifo_q1;

   logic                wr_fire;
   logic                clr_fire;
   logic                rd_issue;
   logic                pop;
   logic                push;
   logic                word_done;
   logic [2:0]          occ;
   logic [DATA_W-1:0]   bank_rd;

   assign cmd_ready = (state == S_IDLE);
   assign wr_ready  = (state == S_WRITE);
   assign wr_fire   = wr_ready & wr_valid;
   assign clr_fire  = (state == S_CLEAR);

   assign rd_valid  = (fifo_cnt != 2'd0);
   assign rd_data   = fifo_q0;
   assign pop       = rd_valid & rd_ready;
   assign push      = inflight;

   // Buffer occupancy including the word in flight. A pop this cycle frees a slot before
   // the new word can land (it lands one cycle later), so it counts as credit; this keeps
   // back-to-back reads at one word per cycle without ever overrunning the 2 entries.
   assign occ       = 3'(fifo_cnt) + 3'(inflight);
   assign rd_issue  = (state == S_READ) && (occ < (pop ? 3'd3 : 3'd2));
   assign word_done = wr_fire | clr_fire | rd_issue;

   assign mem_we      = (wr_fire || clr_fire) ? (NUM_BANKS'(1) << bank) : '0;
   assign mem_addr    = addr;
   assign mem_data_in = wr_fire ? wr_data : '0;
   assign bank_rd     = mem_data_out[int'(bank)*DATA_W +: DATA_W];

   assign busy = (state != S_IDLE) || rd_valid;
   assign err  = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         bank     <= '0;
         addr     <= '0;
         cnt      <= '0;
         err_q    <= 1'b0;
         inflight <= 1'b0;
      end else begin
         err_q    <= 1'b0;
         inflight <= rd_issue;
         if (word_done) begin
            addr <= addr + ADDR_W'(1);
            cnt  <= cnt - LEN_W'(1);
         end
         case (state)
            S_IDLE: begin
               if (cmd_valid && (cmd_op != OP_NOP)) begin
                  if ({1'b0, cmd_bank} >= BANK_LIMIT) begin
                     err_q <= 1'b1;
                  end else begin
                     bank <= cmd_bank;
                     addr <= cmd_addr;
                     cnt  <= cmd_len;
                     case (cmd_op)
                        OP_WRITE: state <= S_WRITE;
                        OP_READ:  state <= S_READ;
                        default:  state <= S_CLEAR;
                     endcase
                  end
               end
            end
            S_WRITE: if (wr_fire && (cnt == '0)) state <= S_IDLE;
            S_CLEAR: if (cnt == '0) state <= S_IDLE;
            S_READ:  if (rd_issue && (cnt == '0)) state <= S_DRAIN;
            S_DRAIN: begin
               // Leave once nothing is in flight and the buffer empties at this edge.
               if (!inflight && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop)))
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Two-entry read buffer, head always in fifo_q0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_cnt <= 2'd0;
         fifo_q0  <= '0;
         fifo_q1  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (fifo_cnt == 2'd0) fifo_q0 <= bank_rd;
               else                  fifo_q1 <= bank_rd;
               fifo_cnt <= fifo_cnt + 2'd1;
            end
            2'b01: begin
               fifo_q0  <= fifo_q1;
               fifo_cnt <= fifo_cnt - 2'd1;
            end
            2'b11: begin
               if (fifo_cnt == 2'd1) begin
                  fifo_q0 <= bank_rd;
               end else begin
                  fifo_q0 <= fifo_q1;
                  fifo_q1 <= bank_rd;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
`timescale 1ns/1ps
module tb_mem_burst_ctrl;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int NB = 3;
   localparam int LW = 8;
   localparam int BW = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = 2'b00;
   logic [BW-1:0]     cmd_bank = '0;
   logic [AW-1:0]     cmd_addr = '0;
   logic [LW-1:0]     cmd_len = '0;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [DW-1:0]     wr_data = '0;
   logic              rd_valid;
   logic              rd_ready = 1'b0;
   logic [DW-1:0]     rd_data;
   logic [NB-1:0]     mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_data_in;
   logic [NB*DW-1:0]  mem_data_out = '0;
   logic              busy;
   logic              err;

   always #5 clk = ~clk;

   mem_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB), .LEN_W(LW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_bank(cmd_bank),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .busy(busy), .err(err)
   );

   // SRAM banks: registered read every cycle, write on mem_we, preset pattern before first use.
   logic [DW-1:0] sram [NB][256];
   bit            sram_ready = 1'b0;
   always @(posedge clk) begin
      if (!sram_ready) begin
         for (int b = 0; b < NB; b++)
            for (int a = 0; a < 256; a++)
               sram[b][a] <= 8'(a*3 + b*7 + 1);
         sram_ready <= 1'b1;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (mem_we[b]) sram[b][mem_addr] <= mem_data_in;
            mem_data_out[b*DW +: DW] <= sram[b][mem_addr];
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state
   typedef struct { int bank; int addr; int data; } wr_t;
   logic [7:0] ref_mem [NB][256];
   wr_t        exp_wr[$];
   int         exp_rd[$];
   int         rd_log[$];

   int checks = 0;
   int errors = 0;
   int accept_cyc = 0;
   int we_cnt = 0, we_first = -1, we_last = -1;
   int rd_beats = 0, err_seen = 0;
   int last_lat = -1, last_span = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_log(input string name, input int idx, input int exp);
      if (rd_log.size() > idx) check(name, 32'(rd_log[idx]), 32'(exp));
      else check({name, "_present"}, 32'(rd_log.size()), 32'(idx + 1));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle comparison of the DUT against the expected write and read streams.
   task automatic scoreboard();
      wr_t e;
      int  x;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (mem_we != '0) begin
               we_cnt++;
               if (we_first < 0) we_first = cyc;
               we_last = cyc;
               if (exp_wr.size() == 0) begin
                  check("unexpected_mem_we", 32'(mem_we), 32'(0));
               end else begin
                  e = exp_wr.pop_front();
                  check("mem_we_onehot", 32'(mem_we), 32'(1) << e.bank);
                  check("mem_addr", 32'(mem_addr), 32'(e.addr));
                  check("mem_data_in", 32'(mem_data_in), 32'(e.data));
               end
            end
            if (rd_valid && rd_ready) begin
               if (exp_rd.size() == 0) begin
                  check("unexpected_rd_beat", 32'(rd_valid), 32'(0));
               end else begin
                  x = exp_rd.pop_front();
                  check("rd_data", 32'(rd_data), 32'(x));
               end
               rd_log.push_back(int'(rd_data));
               rd_beats++;
            end
            if (err) err_seen++;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
      check({tag, "_wr_ready"}, 32'(wr_ready), 32'(0));
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
      check({tag, "_mem_we"}, 32'(mem_we), 32'(0));
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
      check({tag, "_mem_data_in"}, 32'(mem_data_in), 32'(0));
      check({tag, "_busy"}, 32'(busy), 32'(0));
      check({tag, "_err"}, 32'(err), 32'(0));
   endtask

   task automatic send_cmd(input logic [1:0] op, input int bk, input int ad, input int ln);
      int n;
      n = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_bank = BW'(bk); cmd_addr = AW'(ad); cmd_len = LW'(ln);
      while (!cmd_ready && n < 100) begin tick(); n++; end
      check("cmd_ready_wait", 32'(cmd_ready), 32'(1));
      tick();
      accept_cyc = cyc;
      cmd_valid = 1'b0; cmd_op = 2'b00;
   endtask

   task automatic run_write(input int bk, input int ad, input int ln, input int base,
                            input int step, input bit gaps);
      wr_t e;
      int  n;
      for (int i = 0; i <= ln; i++) begin
         e.bank = bk; e.addr = (ad + i) % 256; e.data = (base + i*step) & 255;
         exp_wr.push_back(e);
         ref_mem[bk][e.addr] = 8'(e.data);
      end
      we_cnt = 0; we_first = -1;
      send_cmd(2'b01, bk, ad, ln);
      for (int i = 0; i <= ln; i++) begin
         if (gaps && (i % 2 == 1)) begin wr_valid = 1'b0; tick(); end
         wr_valid = 1'b1;
         wr_data  = DW'((base + i*step) & 255);
         n = 0;
         while (!wr_ready && n < 50) begin tick(); n++; end
         tick();
      end
      wr_valid = 1'b0;
      #5;
      check("wr_all_issued", 32'(exp_wr.size()), 32'(0));
      check("wr_busy_done", 32'(busy), 32'(0));
   endtask

   task automatic run_clear(input int bk, input int ad, input int ln);
      wr_t e;
      int  n;
      for (int i = 0; i <= ln; i++) begin
         e.bank = bk; e.addr = (ad + i) % 256; e.data = 0;
         exp_wr.push_back(e);
         ref_mem[bk][e.addr] = 8'h00;
      end
      we_cnt = 0; we_first = -1;
      send_cmd(2'b11, bk, ad, ln);
      n = 0;
      while (busy && n < 100) begin tick(); n++; end
      #5;
      check("clr_all_issued", 32'(exp_wr.size()), 32'(0));
      check("clr_we_cycles", 32'(we_cnt), 32'(ln + 1));
      check("clr_we_consecutive", 32'(we_last - we_first + 1), 32'(ln + 1));
   endtask

   // mode 0: rd_ready held high; mode 1: toggling with a 5-cycle stall.
   task automatic run_read(input int bk, input int ad, input int ln, input int mode);
      int  k, beats0, first_c, last_c;
      bit  done;
      logic busy_at_last, busy_after, valid_after;
      for (int i = 0; i <= ln; i++) exp_rd.push_back(int'(ref_mem[bk][(ad + i) % 256]));
      rd_log.delete();
      beats0 = rd_beats;
      rd_ready = (mode == 0);
      send_cmd(2'b10, bk, ad, ln);
      last_lat = -1; first_c = -1; last_c = -1;
      busy_at_last = 1'b0; busy_after = 1'b1; valid_after = 1'b1;
      k = 0; done = 1'b0;
      while (!done && k < 300) begin
         if (mode == 1) rd_ready = (k >= 4 && k < 9) ? 1'b0 : (k % 2 == 0);
         #5;
         if (rd_valid && first_c < 0) begin first_c = cyc; last_lat = cyc - accept_cyc; end
         if (last_c >= 0 && cyc == last_c + 1) begin
            busy_after = busy; valid_after = rd_valid; done = 1'b1;
         end else if (rd_valid && rd_ready && exp_rd.size() == 0) begin
            last_c = cyc; busy_at_last = busy;
         end
         if (!done) begin tick(); k++; end
      end
      last_span = last_c - first_c + 1;
      check("rd_finished", 32'(done), 32'(1));
      check("rd_beat_count", 32'(rd_beats - beats0), 32'(ln + 1));
      check("rd_first_latency", 32'(last_lat), 32'(2));
      check("busy_at_last_pop", 32'(busy_at_last), 32'(1));
      check("busy_after_last_pop", 32'(busy_after), 32'(0));
      check("rd_valid_after_last_pop", 32'(valid_after), 32'(0));
      rd_ready = 1'b1;
   endtask

   initial begin
      int e0;
      for (int b = 0; b < NB; b++)
         for (int a = 0; a < 256; a++)
            ref_mem[b][a] = 8'(a*3 + b*7 + 1);
      fork scoreboard(); join_none

      repeat (3) @(posedge clk);
      #6;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      tick();

      // 1: write A0..A3 to bank0 @0x10, read it back
      run_write(0, 8'h10, 3, 8'hA0, 1, 1'b0);
      check("t1_we_cycles", 32'(we_cnt), 32'(4));
      check("t1_we_span", 32'(we_last - we_first + 1), 32'(4));
      run_read(0, 8'h10, 3, 0);
      check_log("t1_beat0", 0, 8'hA0);
      check_log("t1_beat3", 3, 8'hA3);
      check("t1_sustained_span", 32'(last_span), 32'(4));

      // 2: address wrap on bank1 (write with gaps, then read)
      run_write(1, 8'hFE, 3, 8'h11, 8'h11, 1'b1);
      run_read(1, 8'hFE, 3, 0);
      check_log("t2_beat1_addr_ff", 1, 8'h22);
      check_log("t2_beat2_addr_00", 2, 8'h33);
      check("t2_no_err", 32'(err_seen), 32'(0));

      // 3: len 7 read under toggling back-pressure with a stall
      run_read(0, 8'h10, 7, 1);
      check_log("t3_beat3", 3, 8'hA3);
      check_log("t3_beat4", 4, 8'h3D);
      check_log("t3_beat7", 7, 8'h46);

      // 4: clear 16 words of bank1 @0x20, read zeros back
      run_clear(1, 8'h20, 15);
      run_read(1, 8'h20, 15, 0);
      check_log("t4_beat0", 0, 0);
      check_log("t4_beat15", 15, 0);

      // 5: invalid bank, then NOP
      e0 = err_seen;
      send_cmd(2'b01, 3, 8'h00, 0);
      #5;
      check("t5_err_pulse", 32'(err), 32'(1));
      check("t5_busy", 32'(busy), 32'(0));
      check("t5_cmd_ready", 32'(cmd_ready), 32'(1));
      check("t5_wr_ready", 32'(wr_ready), 32'(0));
      tick(); #5;
      check("t5_err_cleared", 32'(err), 32'(0));
      check("t5_err_one_cycle", 32'(err_seen - e0), 32'(1));
      send_cmd(2'b00, 0, 8'h00, 0);
      #5;
      check("t5_nop_busy", 32'(busy), 32'(0));
      tick(); #5;
      check("t5_nop_err", 32'(err_seen - e0), 32'(1));

      // 6: reset during beat 2 of an 8-word write to bank0 @0x40
      for (int i = 0; i < 2; i++) begin
         wr_t e;
         e.bank = 0; e.addr = 8'h40 + i; e.data = 8'hC0 + i;
         exp_wr.push_back(e);
         ref_mem[0][e.addr] = 8'(e.data);
      end
      send_cmd(2'b01, 0, 8'h40, 7);
      for (int i = 0; i < 2; i++) begin
         wr_valid = 1'b1; wr_data = DW'(8'hC0 + i);
         tick();
      end
      wr_valid = 1'b1; wr_data = 8'hC2;
      reset = 1'b1;
      #5;
      check_reset_outputs("midreset");
      tick();
      reset = 1'b0; wr_valid = 1'b0;
      #5;
      check("t6_writes_before_reset", 32'(exp_wr.size()), 32'(0));
      tick();
      run_read(0, 8'h40, 7, 0);
      check_log("t6_word1_written", 1, 8'hC1);
      check_log("t6_word2_untouched", 2, 8'hC7);

      check("final_err_total", 32'(err_seen), 32'(1));
      check("final_rd_queue_empty", 32'(exp_rd.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
